// File: rtl/huffman_pkg.sv
// Shared constants, state encoding and table-checking helpers for the Huffman decoder.
package huffman_pkg;

    localparam int NUM_SYM = 6;
    localparam int MAX_LEN = 8;

    localparam logic [2:0] A1 = 3'd1;
    localparam logic [2:0] A2 = 3'd2;
    localparam logic [2:0] A3 = 3'd3;
    localparam logic [2:0] A4 = 3'd4;
    localparam logic [2:0] A5 = 3'd5;
    localparam logic [2:0] A6 = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_BAD  = 2'd2
    } state_e;

    // Entry k is the mask for a (k+1)-bit code.
    localparam logic [MAX_LEN-1:0][7:0] LEGAL_MASKS = {
        8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01
    };

    function automatic logic mask_legal(input logic [7:0] m);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (m == LEGAL_MASKS[k]) ok = 1'b1;
        end
        return ok;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] m);
        logic [3:0] c;
        c = 4'd0;
        for (int k = 0; k < 8; k++) begin
            c = c + {3'd0, m[k]};
        end
        return c;
    endfunction

endpackage

// File: rtl/huffman_decoder_hc_match.sv
// Per-symbol comparator: masked value equality plus exact code length.
module hc_match
    import huffman_pkg::*;
(
    input  logic [7:0] sh_i,
    input  logic [3:0] len_i,
    input  logic [7:0] hc_i,
    input  logic [7:0] m_i,
    output logic       hit_o
);

    // A zero mask has popcount 0 and can never equal a post-shift length.
    assign hit_o = ((sh_i & m_i) == (hc_i & m_i)) && (len_i == popcount8(m_i));

endmodule

// File: rtl/huffman_decoder.sv
// Serial Huffman decoder: loads a 6-entry code table, then shifts in bits MSB
// first and emits the matching symbol index one cycle after the final bit.
module huffman_decoder
    import huffman_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       code_valid,
    input  logic [7:0] HC1,
    input  logic [7:0] HC2,
    input  logic [7:0] HC3,
    input  logic [7:0] HC4,
    input  logic [7:0] HC5,
    input  logic [7:0] HC6,
    input  logic [7:0] M1,
    input  logic [7:0] M2,
    input  logic [7:0] M3,
    input  logic [7:0] M4,
    input  logic [7:0] M5,
    input  logic [7:0] M6,
    input  logic       bit_valid,
    input  logic       bit_in,
    input  logic       flush,
    output logic       bit_ready,
    output logic       sym_valid,
    output logic [2:0] sym,
    output logic       dec_err,
    output logic       tbl_err
);

    state_e                    state_q, state_d;
    logic [NUM_SYM-1:0][7:0]   hc_q, hc_d, m_q, m_d;
    logic [NUM_SYM-1:0][7:0]   hc_in, m_in;
    logic [7:0]                sh_q, sh_d, sh_next;
    logic [3:0]                len_q, len_d, len_next;
    logic [2:0]                sym_q, sym_d, hit_sym;
    logic                      sym_valid_q, sym_valid_d;
    logic                      dec_err_q, dec_err_d;
    logic [NUM_SYM-1:0]        hit;
    logic                      tbl_ok;

    assign hc_in = {HC6, HC5, HC4, HC3, HC2, HC1};
    assign m_in  = {M6, M5, M4, M3, M2, M1};

    assign sh_next  = {sh_q[6:0], bit_in};
    assign len_next = len_q + 4'd1;

    // Comparators see the candidate accumulator including the incoming bit.
    for (genvar g = 0; g < NUM_SYM; g++) begin : g_match
        hc_match u_match (
            .sh_i  (sh_next),
            .len_i (len_next),
            .hc_i  (hc_q[g]),
            .m_i   (m_q[g]),
            .hit_o (hit[g])
        );
    end

    // Lowest-numbered symbol wins when an ambiguous table yields several hits.
    always_comb begin
        hit_sym = 3'd0;
        for (int i = NUM_SYM - 1; i >= 0; i--) begin
            if (hit[i]) hit_sym = 3'(i + 1);
        end
    end

    // Validity of the table being presented on the load strobe.
    always_comb begin
        tbl_ok = 1'b1;
        for (int i = 0; i < NUM_SYM; i++) begin
            if (!mask_legal(m_in[i])) tbl_ok = 1'b0;
        end
    end

    // Next-state and datapath: table load beats flush beats bit accumulation.
    always_comb begin
        state_d     = state_q;
        hc_d        = hc_q;
        m_d         = m_q;
        sh_d        = sh_q;
        len_d       = len_q;
        sym_d       = sym_q;
        sym_valid_d = 1'b0;
        dec_err_d   = 1'b0;
        if (code_valid) begin
            hc_d    = hc_in;
            m_d     = m_in;
            sh_d    = 8'd0;
            len_d   = 4'd0;
            state_d = tbl_ok ? ST_RUN : ST_BAD;
        end else if (state_q == ST_RUN) begin
            if (flush) begin
                sh_d  = 8'd0;
                len_d = 4'd0;
            end else if (bit_valid) begin
                sh_d  = sh_next;
                len_d = len_next;
                if (|hit) begin
                    sym_d       = hit_sym;
                    sym_valid_d = 1'b1;
                    sh_d        = 8'd0;
                    len_d       = 4'd0;
                end else if (len_next == 4'(MAX_LEN)) begin
                    dec_err_d = 1'b1;
                    sh_d      = 8'd0;
                    len_d     = 4'd0;
                end
            end
        end
    end

    // State, table and output registers; reset discards everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            hc_q        <= '0;
            m_q         <= '0;
            sh_q        <= 8'd0;
            len_q       <= 4'd0;
            sym_q       <= 3'd0;
            sym_valid_q <= 1'b0;
            dec_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hc_q        <= hc_d;
            m_q         <= m_d;
            sh_q        <= sh_d;
            len_q       <= len_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
            dec_err_q   <= dec_err_d;
        end
    end

    assign bit_ready = (state_q == ST_RUN);
    assign tbl_err   = (state_q == ST_BAD);
    assign sym_valid = sym_valid_q;
    assign sym       = sym_q;
    assign dec_err   = dec_err_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder with a bit-string reference model.
module tb_huffman_decoder;

    logic       clk = 1'b0;
    logic       reset, code_valid, bit_valid, bit_in, flush;
    logic [7:0] hc [6];
    logic [7:0] m  [6];
    logic       bit_ready, sym_valid, dec_err, tbl_err;
    logic [2:0] sym;

    int errors = 0;
    int checks = 0;

    huffman_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .HC1 (hc[0]), .HC2 (hc[1]), .HC3 (hc[2]),
        .HC4 (hc[3]), .HC5 (hc[4]), .HC6 (hc[5]),
        .M1  (m[0]),  .M2  (m[1]),  .M3  (m[2]),
        .M4  (m[3]),  .M5  (m[4]),  .M6  (m[5]),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .flush      (flush),
        .bit_ready  (bit_ready),
        .sym_valid  (sym_valid),
        .sym        (sym),
        .dec_err    (dec_err),
        .tbl_err    (tbl_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Code length implied by a mask, or 0 if the mask is not a legal run of ones.
    function automatic int code_len(input logic [7:0] mk);
        for (int k = 1; k <= 8; k++) begin
            if (int'(mk) == (1 << k) - 1) return k;
        end
        return 0;
    endfunction

    // Reference model: state 0 idle, 1 run, 2 bad; accumulated bits kept as an integer.
    int         ms = 0;
    int         acc = 0;
    int         acc_n = 0;
    logic       e_sv = 1'b0;
    logic       e_de = 1'b0;
    logic [2:0] e_sym = 3'd0;
    logic [7:0] mhc [6];
    logic [7:0] mm  [6];

    always @(posedge clk or negedge reset) begin : model
        int  a, an, hit;
        logic ok;
        if (!reset) begin
            ms <= 0; acc <= 0; acc_n <= 0;
            e_sv <= 1'b0; e_de <= 1'b0; e_sym <= 3'd0;
            for (int i = 0; i < 6; i++) begin
                mhc[i] <= 8'd0;
                mm[i]  <= 8'd0;
            end
        end else begin
            e_sv <= 1'b0;
            e_de <= 1'b0;
            if (code_valid) begin
                ok = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    if (code_len(m[i]) == 0) ok = 1'b0;
                    mhc[i] <= hc[i];
                    mm[i]  <= m[i];
                end
                acc <= 0; acc_n <= 0;
                ms  <= ok ? 1 : 2;
            end else if (ms == 1 && flush) begin
                acc <= 0; acc_n <= 0;
            end else if (ms == 1 && bit_valid) begin
                a   = acc * 2 + int'(bit_in);
                an  = acc_n + 1;
                hit = 0;
                for (int i = 5; i >= 0; i--) begin
                    if (code_len(mm[i]) == an && a == int'(mhc[i] & mm[i])) hit = i + 1;
                end
                if (hit != 0) begin
                    e_sv <= 1'b1; e_sym <= 3'(hit); acc <= 0; acc_n <= 0;
                end else if (an == 8) begin
                    e_de <= 1'b1; acc <= 0; acc_n <= 0;
                end else begin
                    acc <= a; acc_n <= an;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        chk("cyc_sym_valid", {7'd0, sym_valid}, {7'd0, e_sv});
        chk("cyc_sym",       {5'd0, sym},       {5'd0, e_sym});
        chk("cyc_dec_err",   {7'd0, dec_err},   {7'd0, e_de});
        chk("cyc_tbl_err",   {7'd0, tbl_err},   {7'd0, (ms == 2)});
        chk("cyc_bit_ready", {7'd0, bit_ready}, {7'd0, (ms == 1)});
    end

    // Present inputs for one cycle; returns just after the capturing edge.
    task automatic drive(input logic cv, input logic bv, input logic b, input logic fl);
        code_valid = cv; bit_valid = bv; bit_in = b; flush = fl;
        @(posedge clk);
        #1;
        code_valid = 1'b0; bit_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic send(input logic b);
        drive(1'b0, 1'b1, b, 1'b0);
    endtask

    task automatic set_common();
        hc[0] = 8'h00; hc[1] = 8'h02; hc[2] = 8'h06;
        hc[3] = 8'h0E; hc[4] = 8'h1E; hc[5] = 8'h1F;
        m[0]  = 8'h01; m[1]  = 8'h03; m[2]  = 8'h07;
        m[3]  = 8'h0F; m[4]  = 8'h1F; m[5]  = 8'h1F;
    endtask

    task automatic load_common();
        set_common();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; code_valid = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; flush = 1'b0;
        for (int i = 0; i < 6; i++) begin hc[i] = 8'd0; m[i] = 8'd0; end

        // Reset values
        #2;
        chk("rst_bit_ready", {7'd0, bit_ready}, 8'd0);
        chk("rst_sym_valid", {7'd0, sym_valid}, 8'd0);
        chk("rst_sym",       {5'd0, sym},       8'd0);
        chk("rst_dec_err",   {7'd0, dec_err},   8'd0);
        chk("rst_tbl_err",   {7'd0, tbl_err},   8'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Bits in IDLE are ignored
        send(1'b0);
        chk("idle_ignore_sv", {7'd0, sym_valid}, 8'd0);
        chk("idle_ready",     {7'd0, bit_ready}, 8'd0);

        // V1
        load_common();
        chk("v1_ready",   {7'd0, bit_ready}, 8'd1);
        chk("v1_tbl_err", {7'd0, tbl_err},   8'd0);
        send(1'b0);
        chk("v1_sv",  {7'd0, sym_valid}, 8'd1);
        chk("v1_sym", {5'd0, sym},       8'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("v1_pulse_end", {7'd0, sym_valid}, 8'd0);
        chk("v1_sym_hold",  {5'd0, sym},       8'd1);

        // V2: 1,0 -> sym 2 ; 1,1,1,1,1 -> sym 6
        send(1'b1);
        chk("v2_b1_sv", {7'd0, sym_valid}, 8'd0);
        send(1'b0);
        chk("v2_sv2",  {7'd0, sym_valid}, 8'd1);
        chk("v2_sym2", {5'd0, sym},       8'd2);
        for (int i = 0; i < 4; i++) begin
            send(1'b1);
            chk("v2_mid_sv", {7'd0, sym_valid}, 8'd0);
        end
        send(1'b1);
        chk("v2_sv6",  {7'd0, sym_valid}, 8'd1);
        chk("v2_sym6", {5'd0, sym},       8'd6);

        // V3: 1,1,1 then flush (with a bit that must be dropped), then 0 -> sym 1
        for (int i = 0; i < 3; i++) begin
            send(1'b1);
            chk("v3_pre_sv", {7'd0, sym_valid}, 8'd0);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        chk("v3_flush_sv", {7'd0, sym_valid}, 8'd0);
        chk("v3_flush_de", {7'd0, dec_err},   8'd0);
        send(1'b0);
        chk("v3_sv",  {7'd0, sym_valid}, 8'd1);
        chk("v3_sym", {5'd0, sym},       8'd1);

        // A bit arriving with the table load is dropped
        set_common();
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        chk("ld_drop_sv", {7'd0, sym_valid}, 8'd0);
        send(1'b0);
        chk("ld_drop_sym", {5'd0, sym}, 8'd1);

        // V4: incomplete table, eight ones -> dec_err
        set_common();
        hc[5] = 8'h1D;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            send(1'b1);
            chk("v4_pre_de", {7'd0, dec_err}, 8'd0);
        end
        send(1'b1);
        chk("v4_de",    {7'd0, dec_err},   8'd1);
        chk("v4_sv",    {7'd0, sym_valid}, 8'd0);
        chk("v4_ready", {7'd0, bit_ready}, 8'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("v4_de_end", {7'd0, dec_err}, 8'd0);

        // Ambiguous table: symbols 1 and 2 both encode "1"; lowest wins
        for (int i = 0; i < 6; i++) begin hc[i] = 8'h00; m[i] = 8'hFF; end
        hc[0] = 8'h01; m[0] = 8'h01;
        hc[1] = 8'h01; m[1] = 8'h01;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b1);
        chk("amb_sv",  {7'd0, sym_valid}, 8'd1);
        chk("amb_sym", {5'd0, sym},       8'd1);

        // V5: non-contiguous mask -> BAD; bits ignored; valid reload recovers
        set_common();
        m[2] = 8'h05;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("v5_tbl_err", {7'd0, tbl_err},   8'd1);
        chk("v5_ready",   {7'd0, bit_ready}, 8'd0);
        send(1'b0);
        chk("v5_bad_sv",  {7'd0, sym_valid}, 8'd0);
        load_common();
        chk("v5_ok_tbl",   {7'd0, tbl_err},   8'd0);
        chk("v5_ok_ready", {7'd0, bit_ready}, 8'd1);
        set_common();
        m[0] = 8'h00;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("zero_mask_tbl", {7'd0, tbl_err}, 8'd1);
        load_common();

        // V6: reset mid-code
        send(1'b1);
        send(1'b1);
        reset = 1'b0;
        #1;
        chk("v6_ready",  {7'd0, bit_ready}, 8'd0);
        chk("v6_sv",     {7'd0, sym_valid}, 8'd0);
        chk("v6_sym",    {5'd0, sym},       8'd0);
        chk("v6_de",     {7'd0, dec_err},   8'd0);
        chk("v6_tbl",    {7'd0, tbl_err},   8'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("v6_post_ready", {7'd0, bit_ready}, 8'd0);
        send(1'b0);
        chk("v6_post_sv", {7'd0, sym_valid}, 8'd0);
        load_common();
        chk("v6_reload_ready", {7'd0, bit_ready}, 8'd1);
        send(1'b0);
        chk("v6_reload_sym", {5'd0, sym}, 8'd1);

        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
